prog_loader: RTL and testbench

- Writer side of the program-memory interface.
- Accepts a byte stream over a valid/ready handshake, packs the bytes into 32-bit instruction words, and writes them sequentially into program memory from address 0.
- Holds the processor in reset (cpu_reset) until the image is fully loaded, then releases it.

---
 rtl/prog_loader.sv | 179 +++++++++++++++++
 tb/tb_prog_loader.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: packs a little-endian byte stream into 32-bit words and writes program memory from address 0,
// holding cpu_reset until the image is in. Define CHECKSUM_EN to require a trailing XOR checksum byte.
module prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    LEN0, LEN1, DATA, WRITE, DONE, ERR
`ifdef CHECKSUM_EN
    , CHK
`endif
  } state_t;

  state_t      state;
  logic [1:0]  byte_idx;
  logic [15:0] len;
  logic [23:0] word_lo;
  logic        xfer;
  logic [16:0] len_in;
  logic [15:0] next_count;

  assign xfer       = in_valid && in_ready;
  assign len_in     = {1'b0, in_data, len[7:0]};
  assign next_count = 16'(words_loaded) + 16'd1;

  always_comb begin
    in_ready = 1'b0;
    case (state)
      LEN0, LEN1, DATA: in_ready = 1'b1;
`ifdef CHECKSUM_EN
      CHK:              in_ready = 1'b1;
`endif
      default:          in_ready = 1'b0;
    endcase
  end

  // Lower three bytes of the word being assembled; the top byte goes straight to mem_wdata.
  always_ff @(posedge clk) begin
    if (state == DATA && xfer) begin
      case (byte_idx)
        2'd0:    word_lo[7:0]   <= in_data;
        2'd1:    word_lo[15:8]  <= in_data;
        2'd2:    word_lo[23:16] <= in_data;
        default: word_lo        <= word_lo;
      endcase
    end
  end

`ifdef CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      csum <= '0;
    else if ((state == DONE || state == ERR) && reload)
      csum <= '0;
    else if (state == DATA && xfer)
      csum <= csum ^ in_data;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= LEN0;
      cpu_reset    <= 1'b1;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
      byte_idx     <= '0;
      len          <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        LEN0: begin
          if (xfer) begin
            len[7:0] <= in_data;
            state    <= LEN1;
          end
        end
        LEN1: begin
          if (xfer) begin
            len[15:8] <= in_data;
            if (len_in == 17'd0) begin
`ifdef CHECKSUM_EN
              state <= CHK;
`else
              state     <= DONE;
              cpu_reset <= 1'b0;
              load_done <= 1'b1;
`endif
            end else if (len_in > DEPTH) begin
              state    <= ERR;
              load_err <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state     <= WRITE;
              mem_we    <= 1'b1;
              mem_addr  <= words_loaded[ADDR_W-1:0];
              mem_wdata <= {in_data, word_lo};
            end
          end
        end
        WRITE: begin
          words_loaded <= words_loaded + (ADDR_W+1)'(1);
          if (next_count == len) begin
`ifdef CHECKSUM_EN
            state <= CHK;
`else
            state     <= DONE;
            cpu_reset <= 1'b0;
            load_done <= 1'b1;
`endif
          end else begin
            state <= DATA;
          end
        end
`ifdef CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            if (in_data == csum) begin
              state     <= DONE;
              cpu_reset <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
            end
          end
        end
`endif
        DONE: begin
          if (reload) begin
            state        <= LEN0;
            cpu_reset    <= 1'b1;
            load_done    <= 1'b0;
            words_loaded <= '0;
            byte_idx     <= '0;
            len          <= '0;
          end
        end
        ERR: begin
          if (reload) begin
            state        <= LEN0;
            load_err     <= 1'b0;
            words_loaded <= '0;
            byte_idx     <= '0;
            len          <= '0;
          end
        end
        default: state <= LEN0;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (ADDR_W=8 and ADDR_W=2) share one byte stream and are checked
// against a word-level image model. Honours CHECKSUM_EN when defined.
module tb_prog_loader;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       reload;

  logic       in_ready_a, mem_we_a, cpu_reset_a, load_done_a, load_err_a;
  logic [7:0] mem_addr_a;
  logic [31:0] mem_wdata_a;
  logic [8:0] words_loaded_a;

  logic       in_ready_b, mem_we_b, cpu_reset_b, load_done_b, load_err_b;
  logic [1:0] mem_addr_b;
  logic [31:0] mem_wdata_b;
  logic [2:0] words_loaded_b;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(8)) dut_a (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
    .reload(reload), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .cpu_reset(cpu_reset_a), .load_done(load_done_a), .load_err(load_err_a),
    .words_loaded(words_loaded_a)
  );

  prog_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
    .reload(reload), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .cpu_reset(cpu_reset_b), .load_done(load_done_b), .load_err(load_err_b),
    .words_loaded(words_loaded_b)
  );

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  img[$];
  logic [31:0] exp_w[$];
  int          got_a_addr[$];
  logic [31:0] got_a_data[$];
  int          got_b_addr[$];
  logic [31:0] got_b_data[$];

  always @(negedge clk) begin
    if (mem_we_a) begin
      got_a_addr.push_back(int'(mem_addr_a));
      got_a_data.push_back(mem_wdata_a);
    end
    if (mem_we_b) begin
      got_b_addr.push_back(int'(mem_addr_b));
      got_b_data.push_back(mem_wdata_b);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_got();
    got_a_addr = {};
    got_a_data = {};
    got_b_addr = {};
    got_b_data = {};
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    if (gap) begin
      in_valid = 1'b0;
      tick();
    end
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready_a && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check("send_ready", in_ready_a, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_image(input bit gap);
    for (int i = 0; i < img.size(); i++) send_byte(img[i], gap);
  endtask

  task automatic wait_end();
    int n = 0;
    while (!((load_done_a || load_err_a) && (load_done_b || load_err_b)) && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic add_csum(input bit corrupt);
`ifdef CHECKSUM_EN
    logic [7:0] x = 8'h00;
    for (int i = 2; i < img.size(); i++) x ^= img[i];
    img.push_back(corrupt ? (x ^ 8'h01) : x);
`else
    if (corrupt) img = img;
`endif
  endtask

  task automatic build_image(input int len, input bit corrupt);
    img = {};
    img.push_back(8'(len));
    img.push_back(8'(len >> 8));
    for (int i = 0; i < 4 * len; i++) img.push_back(8'($urandom));
    add_csum(corrupt);
  endtask

  // Expected outcome of loading img into a memory of 'depth' words.
  task automatic model(input int depth, output bit done, output bit err, output int nw);
    int len;
    logic [7:0] x;
    exp_w = {};
    done = 0;
    err  = 0;
    nw   = 0;
    x    = 8'h00;
    len  = int'(img[0]) + 256 * int'(img[1]);
    if (len > depth) begin
      err = 1;
      return;
    end
    for (int i = 0; i < len; i++) begin
      exp_w.push_back({img[2+4*i+3], img[2+4*i+2], img[2+4*i+1], img[2+4*i]});
      for (int k = 0; k < 4; k++) x ^= img[2+4*i+k];
    end
    nw = len;
`ifdef CHECKSUM_EN
    if (img.size() > 2 + 4 * len && img[2+4*len] == x) done = 1;
    else err = 1;
`else
    done = (x == x);
`endif
  endtask

  task automatic verify(input string tag, input bit which);
    bit d, e;
    int nw, sz, wl, ad;
    logic dn, er, cr, rd;
    logic [31:0] dt;
    model(which ? 4 : 256, d, e, nw);
    dn = which ? load_done_b : load_done_a;
    er = which ? load_err_b  : load_err_a;
    cr = which ? cpu_reset_b : cpu_reset_a;
    rd = which ? in_ready_b  : in_ready_a;
    wl = which ? int'(words_loaded_b) : int'(words_loaded_a);
    sz = which ? got_b_data.size() : got_a_data.size();
    check({tag, "_done"}, dn, d);
    check({tag, "_err"}, er, e);
    check({tag, "_cpu_reset"}, cr, !d);
    check({tag, "_in_ready"}, rd, 0);
    check({tag, "_words_loaded"}, wl, nw);
    check({tag, "_nwrites"}, sz, exp_w.size());
    for (int i = 0; i < exp_w.size() && i < sz; i++) begin
      ad = which ? got_b_addr[i] : got_a_addr[i];
      dt = which ? got_b_data[i] : got_a_data[i];
      check({tag, "_addr"}, ad, i);
      check({tag, "_data"}, dt, exp_w[i]);
    end
  endtask

  task automatic do_reload();
    logic was_done;
    was_done = load_done_a;
    reload = 1'b1;
    tick();
    reload = 1'b0;
    check("reload_cpu_a", cpu_reset_a, 1);
    check("reload_done_a", load_done_a, 0);
    check("reload_err_a", load_err_a, 0);
    check("reload_ready_a", in_ready_a, 1);
    check("reload_cpu_b", cpu_reset_b, 1);
    check("reload_ready_b", in_ready_b, 1);
    if (was_done) check("reload_wl_a", words_loaded_a, 0);
    clear_got();
  endtask

  initial begin
    reset    = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    reload   = 1'b0;
    tick();
    tick();
    check("rst_cpu_reset", cpu_reset_a, 1);
    check("rst_mem_we", mem_we_a, 0);
    check("rst_mem_addr", mem_addr_a, 0);
    check("rst_mem_wdata", mem_wdata_a, 0);
    check("rst_done", load_done_a, 0);
    check("rst_err", load_err_a, 0);
    check("rst_words", words_loaded_a, 0);
    check("rst_in_ready", in_ready_a, 1);
    reset = 1'b0;
    tick();
    clear_got();

    // Basic two-word image
    img = {8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    add_csum(1'b0);
    send_image(1'b0);
    wait_end();
    verify("two_a", 1'b0);
    verify("two_b", 1'b1);
    check("two_word0", got_a_data.size() > 0 ? got_a_data[0] : 32'h0, 32'h00500013);
    check("two_word1", got_a_data.size() > 1 ? got_a_data[1] : 32'h0, 32'h00A00093);
    do_reload();

    // Throttled stream, reset mid-load after the first word lands
    for (int i = 0; i < 7; i++) send_byte(img[i], 1'b1);
    check("mid_words_pre", words_loaded_a, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_cpu_reset", cpu_reset_a, 1);
    check("mid_words", words_loaded_a, 0);
    check("mid_wdata", mem_wdata_a, 0);
    check("mid_we", mem_we_a, 0);
    check("mid_in_ready", in_ready_a, 1);
    check("mid_kept_writes", got_a_addr.size(), 1);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    clear_got();
    send_image(1'b1);
    wait_end();
    verify("clean_a", 1'b0);
    verify("clean_b", 1'b1);
    do_reload();

    // Zero-length image
    img = {8'h00, 8'h00};
    add_csum(1'b0);
    send_image(1'b0);
    check("zero_done_now", load_done_a, 1);
    verify("zero_a", 1'b0);
    verify("zero_b", 1'b1);
    do_reload();
`ifdef CHECKSUM_EN
    img = {8'h00, 8'h00, 8'h01};
    send_image(1'b0);
    wait_end();
    verify("zero_bad_a", 1'b0);
    do_reload();
`endif

    // Oversized length: 257 words
    img = {8'h01, 8'h01};
    send_image(1'b0);
    check("big_err_now", load_err_a, 1);
    verify("big_a", 1'b0);
    verify("big_b", 1'b1);
    in_data  = 8'h55;
    in_valid = 1'b1;
    tick();
    tick();
    tick();
    in_valid = 1'b0;
    check("big_err_hold", load_err_a, 1);
    check("big_ready_hold", in_ready_a, 0);
    do_reload();
    build_image(2, 1'b0);
    send_image(1'b0);
    wait_end();
    verify("after_err_a", 1'b0);
    verify("after_err_b", 1'b1);
    do_reload();

    // Fill the four-word instance, then overwrite from address 0
    build_image(4, 1'b0);
    send_image(1'b0);
    wait_end();
    verify("fill_a", 1'b0);
    verify("fill_b", 1'b1);
    do_reload();
    build_image(1, 1'b0);
    send_image(1'b0);
    wait_end();
    verify("refill_a", 1'b0);
    verify("refill_b", 1'b1);
    do_reload();

    // Random images
    for (int it = 0; it < 10; it++) begin
      build_image(int'($urandom_range(0, 6)), 1'($urandom_range(0, 3) == 0));
      send_image(1'($urandom_range(0, 1)));
      wait_end();
      verify("rnd_a", 1'b0);
      verify("rnd_b", 1'b1);
      do_reload();
    end

`ifdef CHECKSUM_EN
    img = {8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_image(1'b0);
    wait_end();
    verify("csum_ok_a", 1'b0);
    do_reload();
    img = {8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    send_image(1'b0);
    wait_end();
    verify("csum_bad_a", 1'b0);
    check("csum_bad_err", load_err_a, 1);
    do_reload();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
